pipe_controller: RTL and testbench

- Parametrised successor to the single-stage MIPS controller: decodes op/funct in Decode and carries control bundles through E/M/W pipeline registers.
- Supports stall and flush from the hazard / branch-prediction unit.
- Flags illegal opcodes.
- Optional immediate-logic instructions (andi/ori/slti) are enabled by parameter.
- Sits between the instruction register (D stage) and the datapath; replaces per-stage control flops in the datapath.

---
 rtl/pipe_controller.sv | 196 +++++++++++++++++++
 tb/tb_pipe_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// Pipelined MIPS control: decodes op/funct in D and carries
// control bundles through E/M/W with stall and flush support.
package pipe_controller_pkg;
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } id_ex_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } ex_mem_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } mem_wb_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

module pipe_controller
  import pipe_controller_pkg::*;
#(
  parameter int ALUCTRL_W        = 3,
  parameter bit IMM_LOGIC        = 1'b0,
  parameter bit FLUSH_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opD,
  input  logic [5:0]           functD,
  input  logic                 stallE,
  input  logic                 flushE,
  input  logic                 flushM,
  output logic                 branchD,
  output logic                 jumpD,
  output logic                 illegalD,
  output logic                 regwriteE,
  output logic                 memtoregE,
  output logic                 memwriteE,
  output logic                 alusrcE,
  output logic                 regdstE,
  output logic [ALUCTRL_W-1:0] alucontrolE,
  output logic                 regwriteM,
  output logic                 memtoregM,
  output logic                 memwriteM,
  output logic                 regwriteW,
  output logic                 memtoregW
);

  id_ex_t  dec;
  id_ex_t  e_d, e_q;
  ex_mem_t m_d, m_q;
  mem_wb_t w_d, w_q;
  logic [2:0] alu_r;
  logic       funct_ok;
  logic       flush_e;

  always_comb begin
    alu_r    = ALU_AND;
    funct_ok = 1'b1;
    unique case (1'b1)
      functD == FN_ADD: alu_r = ALU_ADD;
      functD == FN_SUB: alu_r = ALU_SUB;
      functD == FN_AND: alu_r = ALU_AND;
      functD == FN_OR:  alu_r = ALU_OR;
      functD == FN_SLT: alu_r = ALU_SLT;
      default:          funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec      = '0;
    branchD  = 1'b0;
    jumpD    = 1'b0;
    illegalD = 1'b0;
    unique case (1'b1)
      opD == OP_RTYPE: begin
        if (funct_ok) begin
          dec.regwrite   = 1'b1;
          dec.regdst     = 1'b1;
          dec.alucontrol = alu_r;
        end else begin
          illegalD = 1'b1;
        end
      end
      opD == OP_LW: begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.memtoreg   = 1'b1;
        dec.alucontrol = ALU_ADD;
      end
      opD == OP_SW: begin
        dec.alusrc     = 1'b1;
        dec.memwrite   = 1'b1;
        dec.alucontrol = ALU_ADD;
      end
      opD == OP_BEQ: begin
        branchD        = 1'b1;
        dec.alucontrol = ALU_SUB;
      end
      opD == OP_ADDI: begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.alucontrol = ALU_ADD;
      end
      opD == OP_J: begin
        jumpD = 1'b1;
      end
      IMM_LOGIC && (opD == OP_ANDI): begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.alucontrol = ALU_AND;
      end
      IMM_LOGIC && (opD == OP_ORI): begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.alucontrol = ALU_OR;
      end
      IMM_LOGIC && (opD == OP_SLTI): begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.alucontrol = ALU_SLT;
      end
      default: illegalD = 1'b1;
    endcase
  end

  // An illegal op may override a stall so it never lingers in E.
  assign flush_e = flushE | (FLUSH_ON_ILLEGAL & illegalD);

  always_comb begin
    e_d = dec;
    if (flush_e) begin
      e_d = '0;
    end else if (stallE) begin
      e_d = e_q;
    end
    m_d = '{e_q.regwrite, e_q.memtoreg, e_q.memwrite};
    if (flushM || stallE) begin
      m_d = '0;
    end
    w_d = '{m_q.regwrite, m_q.memtoreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign regwriteE   = e_q.regwrite;
  assign memtoregE   = e_q.memtoreg;
  assign memwriteE   = e_q.memwrite;
  assign alusrcE     = e_q.alusrc;
  assign regdstE     = e_q.regdst;
  assign alucontrolE = ALUCTRL_W'(e_q.alucontrol);
  assign regwriteM   = m_q.regwrite;
  assign memtoregM   = m_q.memtoreg;
  assign memwriteM   = m_q.memwrite;
  assign regwriteW   = w_q.regwrite;
  assign memtoregW   = w_q.memtoreg;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller across three
// parameter sets sharing one stimulus stream.
module tb_pipe_controller;

  localparam int S_RWE  = 0;
  localparam int S_MTRE = 1;
  localparam int S_MWE  = 2;
  localparam int S_ASE  = 3;
  localparam int S_RDE  = 4;
  localparam int S_ALUE = 5;
  localparam int S_RWM  = 6;
  localparam int S_MTRM = 7;
  localparam int S_MWM  = 8;
  localparam int S_RWW  = 9;
  localparam int S_MTRW = 10;
  localparam int S_BRD  = 11;
  localparam int S_JD   = 12;
  localparam int S_ILD  = 13;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] FADD = 6'b100000;

  typedef struct {
    int         cyc;
    int         dut;
    int         sig;
    logic [3:0] exp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   vecs  = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opD, functD;
  logic       stallE, flushE, flushM;

  wire [2:0] rwE, mtrE, mwE, asE, rdE;
  wire [2:0] rwM, mtrM, mwM, rwW, mtrW;
  wire [2:0] brD, jD, ilD;
  wire [2:0] alu0, alu1;
  wire [3:0] alu2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_controller u0 (
    .clk(clk), .rst(rst), .opD(opD), .functD(functD),
    .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .branchD(brD[0]), .jumpD(jD[0]), .illegalD(ilD[0]),
    .regwriteE(rwE[0]), .memtoregE(mtrE[0]),
    .memwriteE(mwE[0]), .alusrcE(asE[0]),
    .regdstE(rdE[0]), .alucontrolE(alu0),
    .regwriteM(rwM[0]), .memtoregM(mtrM[0]),
    .memwriteM(mwM[0]), .regwriteW(rwW[0]),
    .memtoregW(mtrW[0])
  );

  pipe_controller #(.IMM_LOGIC(1'b1)) u1 (
    .clk(clk), .rst(rst), .opD(opD), .functD(functD),
    .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .branchD(brD[1]), .jumpD(jD[1]), .illegalD(ilD[1]),
    .regwriteE(rwE[1]), .memtoregE(mtrE[1]),
    .memwriteE(mwE[1]), .alusrcE(asE[1]),
    .regdstE(rdE[1]), .alucontrolE(alu1),
    .regwriteM(rwM[1]), .memtoregM(mtrM[1]),
    .memwriteM(mwM[1]), .regwriteW(rwW[1]),
    .memtoregW(mtrW[1])
  );

  pipe_controller #(.ALUCTRL_W(4)) u2 (
    .clk(clk), .rst(rst), .opD(opD), .functD(functD),
    .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .branchD(brD[2]), .jumpD(jD[2]), .illegalD(ilD[2]),
    .regwriteE(rwE[2]), .memtoregE(mtrE[2]),
    .memwriteE(mwE[2]), .alusrcE(asE[2]),
    .regdstE(rdE[2]), .alucontrolE(alu2),
    .regwriteM(rwM[2]), .memtoregM(mtrM[2]),
    .memwriteM(mwM[2]), .regwriteW(rwW[2]),
    .memtoregW(mtrW[2])
  );

  function automatic logic [3:0] get(input int d, input int s);
    logic [3:0] v;
    v = 4'hx;
    case (s)
      S_RWE:  v = {3'b0, rwE[d]};
      S_MTRE: v = {3'b0, mtrE[d]};
      S_MWE:  v = {3'b0, mwE[d]};
      S_ASE:  v = {3'b0, asE[d]};
      S_RDE:  v = {3'b0, rdE[d]};
      S_ALUE: v = (d == 0) ? {1'b0, alu0} :
                  (d == 1) ? {1'b0, alu1} : alu2;
      S_RWM:  v = {3'b0, rwM[d]};
      S_MTRM: v = {3'b0, mtrM[d]};
      S_MWM:  v = {3'b0, mwM[d]};
      S_RWW:  v = {3'b0, rwW[d]};
      S_MTRW: v = {3'b0, mtrW[d]};
      S_BRD:  v = {3'b0, brD[d]};
      S_JD:   v = {3'b0, jD[d]};
      S_ILD:  v = {3'b0, ilD[d]};
      default: v = 4'hx;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [3:0] act;
        act  = get(q[i].dut, q[i].sig);
        vecs = vecs + 1;
        if (act !== q[i].exp) begin
          fails = fails + 1;
          $display("FAIL %s dut%0d cyc%0d: got %h want %h",
                   q[i].nm, q[i].dut, cyc, act, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [5:0] op, input logic [5:0] fn,
                     input logic st, input logic fe,
                     input logic fm, input logic r);
    opD    = op;
    functD = fn;
    stallE = st;
    flushE = fe;
    flushM = fm;
    rst    = r;
  endtask

  task automatic ex(input int dly, input int d, input int s,
                    input logic [3:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dly;
    e.dut = d;
    e.sig = s;
    e.exp = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  logic [5:0] fns [5];
  logic [3:0] alus [5];

  initial begin
    fns  = '{6'b100000, 6'b100010, 6'b101010, 6'b100101, 6'b100100};
    alus = '{4'd2, 4'd6, 4'd7, 4'd1, 4'd0};
    drv(LW, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    tick();
    ex(0, 0, S_RWE, 0, "rst_rwE");
    ex(0, 0, S_MTRE, 0, "rst_mtrE");
    ex(0, 0, S_ASE, 0, "rst_asE");
    ex(0, 0, S_ALUE, 0, "rst_aluE");
    ex(0, 0, S_RWM, 0, "rst_rwM");
    ex(0, 0, S_RWW, 0, "rst_rwW");
    tick();
    ex(0, 0, S_MTRE, 0, "rst2_mtrE");
    ex(0, 0, S_RWW, 0, "rst2_rwW");
    drv(LW, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(0, 0, S_ILD, 0, "lw_ilD");
    ex(1, 0, S_MTRE, 1, "lw_mtrE");
    ex(1, 0, S_ASE, 1, "lw_asE");
    ex(1, 0, S_ALUE, 2, "lw_aluE");
    ex(2, 0, S_RWM, 1, "lw_rwM");
    ex(3, 0, S_RWW, 1, "lw_rwW");
    ex(3, 0, S_MTRW, 1, "lw_mtrW");

    for (int i = 0; i < 5; i++) begin
      tick();
      drv(6'd0, fns[i], 1'b0, 1'b0, 1'b0, 1'b0);
      ex(1, 0, S_ALUE, alus[i], "rtype_aluE");
      ex(1, 0, S_RDE, 1, "rtype_rdE");
      ex(1, 0, S_RWE, 1, "rtype_rwE");
    end

    tick();
    drv(SW, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(1, 0, S_MWE, 1, "stall_mwE1");
    ex(2, 0, S_MWE, 1, "stall_mwE2");
    ex(3, 0, S_MWE, 1, "stall_mwE3");
    ex(4, 0, S_MWE, 0, "stall_mwE4");
    ex(2, 0, S_MWM, 0, "stall_mwM2");
    ex(3, 0, S_MWM, 0, "stall_mwM3");
    ex(4, 0, S_MWM, 1, "stall_mwM4");
    ex(5, 0, S_MWM, 0, "stall_mwM5");
    ex(2, 0, S_RWM, 0, "stall_rwM2");
    ex(3, 0, S_RWM, 0, "stall_rwM3");
    ex(3, 0, S_RWW, 0, "stall_rwW3");
    ex(4, 0, S_RWW, 0, "stall_rwW4");
    tick();
    drv(6'd0, FADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(6'd0, FADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(6'd0, FADD, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(1, 0, S_RWE, 1, "unstall_rwE");
    tick();
    drv(6'd0, FADD, 1'b0, 1'b0, 1'b0, 1'b0);

    tick();
    drv(ADDI, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    ex(1, 0, S_RWE, 0, "fe_st_rwE");
    ex(1, 0, S_ASE, 0, "fe_st_asE");
    ex(1, 0, S_RWM, 0, "fe_st_rwM");
    tick();
    drv(ADDI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(1, 0, S_RWE, 1, "addi_rwE");
    ex(1, 0, S_ASE, 1, "addi_asE");
    ex(1, 0, S_ALUE, 2, "addi_aluE");
    tick();
    drv(6'd0, FADD, 1'b0, 1'b0, 1'b1, 1'b0);
    ex(1, 0, S_RWE, 1, "fm_rwE");
    ex(1, 0, S_RDE, 1, "fm_rdE");
    ex(1, 0, S_RWM, 0, "fm_rwM");
    tick();
    drv(JMP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(0, 0, S_JD, 1, "j_jD");
    ex(0, 0, S_BRD, 0, "j_brD");
    ex(1, 0, S_RWE, 0, "j_rwE");
    ex(1, 0, S_RWM, 1, "j_rwM");
    #1;
    vecs = vecs + 1;
    if (jD[0] !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL direct j_jD: got %b", jD[0]);
    end

    tick();
    drv(ORI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(0, 0, S_ILD, 1, "ori0_ilD");
    ex(1, 0, S_RWE, 0, "ori0_rwE");
    ex(1, 0, S_ASE, 0, "ori0_asE");
    ex(1, 0, S_ALUE, 0, "ori0_aluE");
    ex(0, 1, S_ILD, 0, "ori1_ilD");
    ex(1, 1, S_RWE, 1, "ori1_rwE");
    ex(1, 1, S_ASE, 1, "ori1_asE");
    ex(1, 1, S_ALUE, 1, "ori1_aluE");
    ex(0, 2, S_ILD, 1, "ori2_ilD");
    #1;
    vecs = vecs + 1;
    if (ilD[0] !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL direct ori0_ilD: got %b", ilD[0]);
    end
    vecs = vecs + 1;
    if (ilD[1] !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL direct ori1_ilD: got %b", ilD[1]);
    end
    tick();
    drv(ANDI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(0, 0, S_ILD, 1, "andi0_ilD");
    ex(1, 1, S_RWE, 1, "andi1_rwE");
    ex(1, 1, S_ALUE, 0, "andi1_aluE");
    tick();
    drv(SLTI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(0, 0, S_ILD, 1, "slti0_ilD");
    ex(1, 1, S_ALUE, 7, "slti1_aluE");

    tick();
    drv(LW, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(1, 0, S_RWE, 1, "pre_ill_rwE");
    ex(1, 0, S_MTRE, 1, "pre_ill_mtrE");
    tick();
    drv(6'd0, 6'b111111, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(0, 0, S_ILD, 1, "badfn_ilD");
    ex(1, 0, S_RWE, 0, "ill_st_rwE");
    ex(1, 0, S_MTRE, 0, "ill_st_mtrE");
    ex(1, 1, S_RWE, 0, "ill_st_rwE1");
    tick();
    drv(6'b111111, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(0, 0, S_ILD, 1, "badop_ilD");
    ex(0, 1, S_ILD, 1, "badop_ilD1");

    tick();
    drv(BEQ, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(0, 2, S_BRD, 1, "beq_brD");
    ex(0, 2, S_JD, 0, "beq_jD");
    ex(1, 2, S_ALUE, 6, "beq_aluE4");
    ex(1, 2, S_RWE, 0, "beq_rwE");
    ex(1, 0, S_ALUE, 6, "beq_aluE3");
    #1;
    vecs = vecs + 1;
    if (brD[2] !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL direct beq_brD: got %b", brD[2]);
    end
    tick();
    drv(6'd0, FADD, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(6'd0, FADD, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(6'd0, FADD, 1'b0, 1'b0, 1'b0, 1'b1);
    ex(0, 2, S_RWM, 1, "prerst_rwM");
    ex(1, 2, S_RWM, 0, "midrst_rwM");
    ex(1, 2, S_RWW, 0, "midrst_rwW");
    ex(1, 2, S_RWE, 0, "midrst_rwE");
    tick();
    drv(6'd0, FADD, 1'b0, 1'b0, 1'b0, 1'b0);
    ex(1, 2, S_RWE, 1, "postrst_rwE");
    ex(1, 2, S_ALUE, 2, "postrst_aluE");

    for (int i = 0; i < 6; i++) tick();

    foreach (q[i]) begin
      vecs  = vecs + 1;
      fails = fails + 1;
      $display("FAIL %s dut%0d: never checked, want %h",
               q[i].nm, q[i].dut, q[i].exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
